// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
//   pc_state_e           : fetch FSM states (BOOT, RUN, HALTED)
//   PC_ALIGN_BITS        : number of low PC bits that must be zero
//   DEFAULT_RESET_VECTOR : default PC loaded on reset
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    localparam int PC_ALIGN_BITS = 2;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage : pc_pkg

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational priority mux choosing the next fetch PC.
// Optional feature macro: PC_MISALIGN_CHECK_EN (misaligned redirects are dropped).
// Ports:
//   pc              in  XLEN  current PC
//   trap            in  1     trap request (already qualified by caller)
//   trap_vector     in  XLEN  trap handler address (low bits forced to zero)
//   redirect        in  1     redirect request (already qualified by caller)
//   redirect_target in  XLEN  redirect address
//   transfer        in  1     fetch handshake completed this cycle
//   next_pc         out XLEN  PC to load at the next edge
//   pc_plus_inc     out XLEN  pc + PC_INC (wraps silently)
//   misaligned      out 1     redirect_target has nonzero low bits
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int PC_INC = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            transfer,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] LOW_MASK   = XLEN'((1 << PC_ALIGN_BITS) - 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~LOW_MASK;

    logic redirect_take;

    assign pc_plus_inc = pc + XLEN'(PC_INC);
    assign misaligned  = |(redirect_target & LOW_MASK);

`ifdef PC_MISALIGN_CHECK_EN
    // A misaligned redirect is dropped; the PC falls through to advance/hold.
    assign redirect_take = redirect && !misaligned;
`else
    assign redirect_take = redirect;
`endif

    always_comb begin
        next_pc = pc;
        if (trap) begin
            next_pc = trap_vector & ALIGN_MASK;
        end else if (redirect_take) begin
            next_pc = redirect_target & ALIGN_MASK;
        end else if (transfer) begin
            next_pc = pc_plus_inc;
        end
    end

endmodule : pc_next_sel

// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with valid/ready request to instruction memory,
// stall, redirect, trap vectoring and a BOOT/RUN/HALTED state machine.
// Optional feature macro: PC_MISALIGN_CHECK_EN (drop misaligned redirects and
// pulse misalign_err the cycle after; otherwise misalign_err is tied low).
// Ports:
//   clk, reset (async, active high)
//   stall, redirect, redirect_target, trap, trap_vector, halt, resume, pc_ready : inputs
//   pc_out, pc_valid, pc_plus_inc, halted, misalign_err                         : outputs
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              PC_INC       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            halt,
    input  logic            resume,
    input  logic            pc_ready,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            halted,
    output logic            misalign_err
);

    pc_state_e       state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next, sel_pc;
    logic            in_run, transfer, sel_trap, sel_redirect, misaligned;

    assign in_run   = (state_reg == RUN);
    assign pc_valid = in_run && !stall;
    assign transfer = pc_valid && pc_ready;
    assign pc_out   = pc_reg;
    assign halted   = (state_reg == HALTED);

    // Trap is honoured in RUN and HALTED; redirect only in RUN. Transfer is
    // already zero outside RUN, so in HALTED the mux yields trap_vector or hold.
    assign sel_trap     = trap && (state_reg != BOOT);
    assign sel_redirect = redirect && in_run;

    pc_next_sel #(
        .XLEN   (XLEN),
        .PC_INC (PC_INC)
    ) u_next_sel (
        .pc              (pc_reg),
        .trap            (sel_trap),
        .trap_vector     (trap_vector),
        .redirect        (sel_redirect),
        .redirect_target (redirect_target),
        .transfer        (transfer),
        .next_pc         (sel_pc),
        .pc_plus_inc     (pc_plus_inc),
        .misaligned      (misaligned)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = sel_pc;
        case (state_reg)
            BOOT: begin
                state_next = RUN;
                pc_next    = pc_reg;
            end
            RUN: begin
                // A simultaneous trap overrides the halt request.
                if (halt && !trap) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (trap || (resume && !halt)) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
                pc_next    = pc_reg;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_VECTOR;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

`ifdef PC_MISALIGN_CHECK_EN
    logic misalign_err_reg;

    // Flag only redirects that would otherwise have won the priority mux.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err_reg <= 1'b0;
        end else begin
            misalign_err_reg <= sel_redirect && !trap && misaligned;
        end
    end

    assign misalign_err = misalign_err_reg;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign misalign_err      = 1'b0;
`endif

endmodule : pc_unit
